// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared ALU encodings, instruction field positions and control bundle type
// Purpose: constants and types shared by the decode-stage control path.
// Ports: none (package).
package arm_ctrl_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Instruction field bit positions
  localparam int CLASS_HI = 27;
  localparam int CLASS_LO = 25;
  localparam int OPC_HI   = 24;
  localparam int OPC_LO   = 21;
  localparam int S_BIT    = 20;  // S for data processing, L for load/store
  localparam int U_BIT    = 23;
  localparam int I_BIT    = 25;
  localparam int LINK_BIT = 24;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       status;
    logic [1:0] alu_op;
    logic       pc_src;
  } ctrl_t;

endpackage

// File: rtl/arm_decode_control_if.sv
// rtl/arm_decode_control_if.sv - decode-stage control bus interface
// Purpose: groups PC/instruction/bubble inputs and the decoded and ID/EX control outputs.
// master: drives pc_current, instruction, mux_select; observes all outputs.
// slave : the decode-control block.
interface arm_decode_control_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc_current;
  logic [31:0]      instruction;
  logic             mux_select;
  logic [WIDTH-1:0] pc_plus_4;
  logic             reg_write_enable;
  logic             mem_write_enable;
  logic             mem_to_reg_select;
  logic             alu_source_select;
  logic             status_bit;
  logic [1:0]       alu_operation;
  logic             pc_source_select;
  logic             ex_reg_write_enable;
  logic             ex_mem_write_enable;
  logic             ex_mem_to_reg_select;
  logic             ex_alu_src_select;
  logic             ex_pc_src_select;
  logic [1:0]       ex_status_bits;
  logic [1:0]       ex_alu_control;

  modport master (
    output pc_current, instruction, mux_select,
    input  pc_plus_4, reg_write_enable, mem_write_enable, mem_to_reg_select,
           alu_source_select, status_bit, alu_operation, pc_source_select,
           ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select,
           ex_alu_src_select, ex_pc_src_select, ex_status_bits, ex_alu_control
  );

  modport slave (
    input  pc_current, instruction, mux_select,
    output pc_plus_4, reg_write_enable, mem_write_enable, mem_to_reg_select,
           alu_source_select, status_bit, alu_operation, pc_source_select,
           ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select,
           ex_alu_src_select, ex_pc_src_select, ex_status_bits, ex_alu_control
  );
endinterface

// File: rtl/add32.sv
// rtl/add32.sv - parameterized wrapping adder
// Purpose: out = (in_a + in_b) mod 2^WIDTH, no carry out.
// Ports: in_a, in_b (WIDTH in), out (WIDTH out).
module add32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out
);
  assign out = in_a + in_b;
endmodule

// File: rtl/arm_decode_control.sv
// rtl/arm_decode_control.sv - ID-stage PC+4, instruction decode, bubble mux and ID/EX control register
// Purpose: decodes the IF/ID instruction into datapath control, optionally bubbles it,
//          and registers it into the ID/EX control bundle.
// Ports: clk, reset (async active-low), bus (slave modport: pc_current, instruction,
//        mux_select in; pc_plus_4, decoded control, ex_* registered control out).
module arm_decode_control
  import arm_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input logic                  clk,
  input logic                  reset,
  arm_decode_control_if.slave  bus
);

  ctrl_t      dec;
  ctrl_t      muxed;
  ctrl_t      ex_q;
  logic [31:0] instr;
  logic [3:0]  opcode;

  assign instr  = bus.instruction;
  assign opcode = instr[OPC_HI:OPC_LO];

  add32 #(.WIDTH(WIDTH)) u_pc_add (
    .in_a (bus.pc_current),
    .in_b (WIDTH'(PC_INC)),
    .out  (bus.pc_plus_4)
  );

  // First match wins: NOP, branch, load/store, data processing, else nothing.
  always_comb begin
    dec = '0;
    if (instr != 32'h0000_0000) begin
      if (instr[CLASS_HI:CLASS_LO] == 3'b101) begin
        // Condition field is resolved downstream; BL also writes LR.
        dec.pc_src    = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = instr[LINK_BIT];
      end else if (instr[CLASS_HI:CLASS_HI-1] == 2'b01) begin
        // I=0 means immediate offset for load/store.
        dec.alu_src    = ~instr[I_BIT];
        dec.alu_op     = instr[U_BIT] ? ALU_ADD : ALU_SUB;
        dec.reg_write  = instr[S_BIT];
        dec.mem_to_reg = instr[S_BIT];
        dec.mem_write  = ~instr[S_BIT];
      end else if (instr[CLASS_HI:CLASS_HI-1] == 2'b00) begin
        dec.alu_src = instr[I_BIT];
        dec.status  = instr[S_BIT];
        case (opcode)
          4'b0000: dec.alu_op = ALU_AND;
          4'b0100: dec.alu_op = ALU_ADD;
          4'b0010: dec.alu_op = ALU_SUB;
          4'b1100: dec.alu_op = ALU_ORR;
          4'b1010: dec.alu_op = ALU_SUB;
          default: dec.alu_op = ALU_ADD;
        endcase
        // TST/TEQ/CMP/CMN only set flags.
        dec.reg_write = (opcode[3:2] != 2'b10);
      end
    end
  end

  always_comb begin
    muxed = dec;
    if (bus.mux_select) begin
      muxed = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= muxed;
    end
  end

  assign bus.reg_write_enable     = dec.reg_write;
  assign bus.mem_write_enable     = dec.mem_write;
  assign bus.mem_to_reg_select    = dec.mem_to_reg;
  assign bus.alu_source_select    = dec.alu_src;
  assign bus.status_bit           = dec.status;
  assign bus.alu_operation        = dec.alu_op;
  assign bus.pc_source_select     = dec.pc_src;

  assign bus.ex_reg_write_enable  = ex_q.reg_write;
  assign bus.ex_mem_write_enable  = ex_q.mem_write;
  assign bus.ex_mem_to_reg_select = ex_q.mem_to_reg;
  assign bus.ex_alu_src_select    = ex_q.alu_src;
  assign bus.ex_pc_src_select     = ex_q.pc_src;
  assign bus.ex_status_bits       = {1'b0, ex_q.status};
  assign bus.ex_alu_control       = ex_q.alu_op;

endmodule

// File: tb/tb_arm_decode_control.sv
// tb/tb_arm_decode_control.sv - self-checking bench for arm_decode_control
module tb_arm_decode_control;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  arm_decode_control_if #(.WIDTH(32)) bus ();

  arm_decode_control #(.WIDTH(32), .PC_INC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Packed view: {rw, mw, mtr, asrc, s, alu[1:0], pcsrc}
  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [7:0]  exp;
  } vec_t;

  function automatic logic [7:0] comb_view();
    return {bus.reg_write_enable, bus.mem_write_enable, bus.mem_to_reg_select,
            bus.alu_source_select, bus.status_bit, bus.alu_operation, bus.pc_source_select};
  endfunction

  // {rw, mw, mtr, asrc, status_bits[1:0], alu[1:0], pcsrc}
  function automatic logic [8:0] ex_view();
    return {bus.ex_reg_write_enable, bus.ex_mem_write_enable, bus.ex_mem_to_reg_select,
            bus.ex_alu_src_select, bus.ex_status_bits, bus.ex_alu_control, bus.ex_pc_src_select};
  endfunction

  function automatic logic [8:0] widen(input logic [7:0] c);
    return {c[7:4], 1'b0, c[3:0]};
  endfunction

  // Reference decoder built from the instruction-class rules.
  function automatic logic [7:0] model(input logic [31:0] ins);
    int  cls, op;
    bit  rw, mw, mtr, asrc, s, pcs;
    int  alu;
    rw = 0; mw = 0; mtr = 0; asrc = 0; s = 0; pcs = 0; alu = 0;
    cls = int'(ins[27:25]);
    op  = int'(ins[24:21]);
    if (ins == 0) begin
    end else if (cls == 5) begin
      pcs = 1; asrc = 1; rw = ins[24];
    end else if (cls == 2 || cls == 3) begin
      asrc = !ins[25];
      alu  = ins[23] ? 0 : 1;
      if (ins[20]) begin rw = 1; mtr = 1; end
      else mw = 1;
    end else if (cls == 0 || cls == 1) begin
      asrc = ins[25];
      s    = ins[20];
      if (op == 0) alu = 2;
      else if (op == 2 || op == 10) alu = 1;
      else if (op == 12) alu = 3;
      else alu = 0;
      rw = !(op >= 8 && op <= 11);
    end
    return {rw, mw, mtr, asrc, s, 2'(alu), pcs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic [7:0] pend;

  initial begin
    vecs.push_back('{"ANDS_imm", 32'hE2110000, 8'h9C});
    vecs.push_back('{"AND_imm",  32'hE2010000, 8'h94});
    vecs.push_back('{"ADD_reg",  32'hE0805183, 8'h80});
    vecs.push_back('{"LDRB",     32'hE7D12000, 8'hA0});
    vecs.push_back('{"STR",      32'hE58A5000, 8'h50});
    vecs.push_back('{"BNE",      32'h1AFFFFFD, 8'h11});
    vecs.push_back('{"BLLE",     32'hDB000009, 8'h91});
    vecs.push_back('{"NOP",      32'h00000000, 8'h00});
    vecs.push_back('{"CMP_imm",  32'hE3500000, 8'h1A});
    vecs.push_back('{"LDR_down", 32'hE5112004, 8'hB2});
    vecs.push_back('{"ORR_reg",  32'hE1810002, 8'h86});
    vecs.push_back('{"SUB_reg",  32'hE0410002, 8'h82});
    vecs.push_back('{"MOV_reg",  32'hE1A00001, 8'h80});
    vecs.push_back('{"TST_reg",  32'hE1100000, 8'h08});
    vecs.push_back('{"undef_11", 32'hEC000000, 8'h00});

    // Reset held low: registers stay clear across edges.
    reset = 1'b0;
    bus.pc_current  = 32'h0;
    bus.instruction = 32'hE2110000;
    bus.mux_select  = 1'b0;
    #1;
    chk("reset_async_ex", 32'(ex_view()), 32'h0);
    chk("pc_0", bus.pc_plus_4, 32'h4);
    chk("comb_in_reset", 32'(comb_view()), 32'h9C);
    tick();
    tick();
    chk("reset_hold_ex", 32'(ex_view()), 32'h0);
    bus.pc_current = 32'hFFFFFFFC;
    #1;
    chk("pc_wrap", bus.pc_plus_4, 32'h0);

    // First capture after reset release
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ex_before_first_edge", 32'(ex_view()), 32'h0);
    tick();
    chk("ANDS_ex_status", 32'(bus.ex_status_bits), 32'h1);

    // Table
    foreach (vecs[i]) begin
      bus.instruction = vecs[i].ins;
      bus.mux_select  = 1'b0;
      #1;
      chk({vecs[i].name, "_dec"}, 32'(comb_view()), 32'(vecs[i].exp));
      tick();
      chk({vecs[i].name, "_ex"}, 32'(ex_view()), 32'(widen(vecs[i].exp)));
    end

    // Bubble: decode unaffected, registered bundle cleared, then restored
    bus.instruction = 32'hE0805183;
    bus.mux_select  = 1'b1;
    #1;
    chk("bubble_dec", 32'(comb_view()), 32'h80);
    tick();
    chk("bubble_ex", 32'(ex_view()), 32'h0);
    bus.mux_select = 1'b0;
    #1;
    chk("unbubble_before_edge", 32'(ex_view()), 32'h0);
    tick();
    chk("unbubble_ex", 32'(ex_view()), 32'(widen(8'h80)));

    // mux_select toggled mid-cycle: only the edge value counts
    bus.instruction = 32'hE2110000;
    bus.mux_select  = 1'b1;
    #2;
    bus.mux_select  = 1'b0;
    tick();
    chk("glitch_pass_ex", 32'(ex_view()), 32'(widen(8'h9C)));
    bus.mux_select  = 1'b0;
    #2;
    bus.mux_select  = 1'b1;
    tick();
    chk("glitch_bubble_ex", 32'(ex_view()), 32'h0);

    // Async reset mid-cycle
    bus.mux_select = 1'b0;
    tick();
    chk("pre_async_ex", 32'(ex_view()), 32'(widen(8'h9C)));
    #1;
    reset = 1'b0;
    #1;
    chk("async_clear_ex", 32'(ex_view()), 32'h0);
    chk("comb_ignores_reset", 32'(comb_view()), 32'h9C);
    @(negedge clk);
    reset = 1'b1;

    // Randomized against the reference model
    pend = '0;
    tick();
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins, pc;
      logic        mx;
      if (k > 0) chk("rnd_ex", 32'(ex_view()), 32'(widen(pend)));
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[27:25] = 3'b101;
        1: ins[27:26] = 2'b01;
        2: ins[27:26] = 2'b00;
        3: ins = 32'h0;
        default: ;
      endcase
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      mx = ($urandom_range(0, 3) == 0);
      bus.instruction = ins;
      bus.pc_current  = pc;
      bus.mux_select  = mx;
      #1;
      chk("rnd_dec", 32'(comb_view()), 32'(model(ins)));
      chk("rnd_pc", bus.pc_plus_4, pc + 32'd4);
      pend = mx ? 8'h00 : model(ins);
      tick();
    end
    chk("rnd_ex_last", 32'(ex_view()), 32'(widen(pend)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_decode_control.md
# arm_decode_control

Decode-stage control path of the 5-stage ARM pipeline. It computes the sequential fetch address (PC+4) with a 32-bit adder. It decodes the instruction held in IF/ID into datapath control signals. It passes those signals through a bubble multiplexer and registers the result as the ID/EX control bundle.

## Interface
- `WIDTH`, 32, adder/PC/instruction width.
- `PC_INC`, 4, constant added to the PC.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all registered outputs.
- `pc_current`  in  WIDTH  current program counter.
- `instruction`  in  32  IF/ID instruction.
- `mux_select`  in  1  1 = insert bubble (force all control to 0), 0 = pass decoded control.
- `pc_plus_4`  out  WIDTH  pc_current + PC_INC, combinational.
- `reg_write_enable`  out  1  decoded register-file write enable, combinational.
- `mem_write_enable`  out  1  decoded data-memory write enable, combinational.
- `mem_to_reg_select`  out  1  decoded: 1 = write back memory data, combinational.
- `alu_source_select`  out  1  decoded: 1 = immediate operand, 0 = register operand, combinational.
- `status_bit`  out  1  decoded S (flag update), combinational.
- `alu_operation`  out  2  decoded ALU op, combinational.
- `pc_source_select`  out  1  decoded branch, combinational.
- `ex_reg_write_enable`, `ex_mem_write_enable`, `ex_mem_to_reg_select`, `ex_alu_src_select`, `ex_pc_src_select`  out  1 each  registered muxed control.
- `ex_status_bits`  out  2  registered {1'b0, muxed status_bit}.
- `ex_alu_control`  out  2  registered muxed alu_operation.

## Operation
- Adder: `pc_plus_4` = (pc_current + PC_INC) mod 2^WIDTH. There is no carry out, and the result wraps (0xFFFFFFFC → 0x00000000).
- ALU op encoding: ADD=00, SUB=01, AND=10, ORR=11.
- Decode priority: first match wins.
  1. Instruction 32'h00000000: NOP. All control outputs are 0.
  2. Branch, bits[27:25]=101: pc_source_select=1, alu_source_select=1, ALU=ADD. reg_write_enable=bit[24] (BL writes LR). All other outputs 0. The condition field is ignored here and is evaluated downstream.
  3. Load/store, bits[27:26]=01:
     - alu_source_select=~bit[25] (immediate offset → 1).
     - ALU=ADD if U (bit[23])=1, else SUB.
     - L (bit[20])=1: reg_write_enable=1, mem_to_reg_select=1.
     - L=0: mem_write_enable=1.
     - status_bit=0; byte/word (bit[22]) does not affect control.
  4. Data processing, bits[27:26]=00:
     - alu_source_select=bit[25]; status_bit=bit[20].
     - Opcode bits[24:21]: 0000→AND, 0100→ADD, 0010→SUB, 1100→ORR, 1010 (CMP)→SUB. All other opcodes→ADD.
     - reg_write_enable=1, except for opcodes 1000–1011 (TST/TEQ/CMP/CMN), which give 0.
  5. Anything else: all control outputs are 0.
- Bubble mux: when mux_select=1, every muxed signal is 0. When mux_select=0, every muxed signal equals its decoded value. The status output widens to 2 bits as {1'b0, status_bit}.

## Timing
- Adder, decoder and mux are purely combinational, with zero-cycle latency.
- `ex_*` registers capture the muxed control on every rising clk edge, with no enable. The decode-to-ex latency is 1 cycle.
- When reset is asserted low, all `ex_*` outputs go to 0 immediately, without waiting for a clock edge. They stay 0 while reset is low.
- The first capture happens on the first rising edge after reset rises.
- If mux_select changes mid-cycle, only the value present at the clock edge is registered.
- Combinational outputs do not depend on reset.

## Structure
- Shared package `arm_ctrl_pkg`:
  - ALU op localparams (ALU_ADD/SUB/AND/ORR).
  - Instruction-class field constants (bit positions 27:25, 24:21, 20, 23, 25).
  - Packed struct `ctrl_t` for the 7-signal control bundle.
- Sub-module `add32`: parameterized WIDTH adder (in_a, in_b, out). It is instantiated once, with in_b tied to PC_INC.
- Decoder and bubble mux live in the top module as always_comb blocks.

## Test plan
- Reset and adder:
  - Hold reset=0 → all ex_* are 0.
  - pc_current=0x0 → pc_plus_4=0x4.
  - pc_current=0xFFFFFFFC → pc_plus_4=0x0.
- DP immediate:
  - 0xE2110000 (ANDS) → RW=1, ALUSrc=1, S=1, ALU=10.
  - 0xE2010000 (AND) → same but S=0.
  - Next edge: ex_status_bits=01 for ANDS.
- DP register: 0xE0805183 (ADD) → RW=1, ALUSrc=0, S=0, ALU=00, MemW=0, MemtoReg=0.
- Memory:
  - 0xE7D12000 (LDRB) → RW=1, MemtoReg=1, ALUSrc=0, ALU=00.
  - 0xE58A5000 (STR) → MemW=1, RW=0, ALUSrc=1, ALU=00.
- Branch/NOP:
  - 0x1AFFFFFD (BNE) → PCSrc=1, RW=0.
  - 0xDB000009 (BLLE) → PCSrc=1, RW=1.
  - 0x00000000 → all 0.
- Bubble: ADD decoded with mux_select=1 → raw outputs unchanged, all ex_* are 0 after the edge. Clearing mux_select restores pass-through on the next edge.
